mem_copy_engine: RTL

- Initiator for the 8-bit, 256-byte data-memory port: combinational read, write on the clock edge when write enable is high.
- Copies a block of `len` bytes from `src_addr` to `dst_addr` through that single port; one read cycle then one write cycle per byte.
- Sits beside the core as a block-move helper; the core starts it and either polls `busy` or waits for the `done` pulse.
- While `busy` is high the engine owns the memory port; the core must not drive the port.

---
 rtl/mem_copy_engine.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Block-move helper for the single-port 8-bit data memory. The memory reads
// combinationally and writes on the clock edge. After a start request, the
// engine copies `len` bytes from `src_addr` to `dst_addr` in ascending order.
// Each byte takes one READ cycle followed by one WRITE cycle. Addresses wrap
// modulo 2^AW. Overlapping regions are not protected.
//
// Optional feature (compile-time macro MEM_COPY_CHECKSUM_EN):
//   When the macro is defined, the block adds the output port `checksum`. It
//   holds the mod-2^DW sum of every byte read during the current copy.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   copy request, honoured only while idle
//   src_addr   in   AW  first source byte address (captured at start)
//   dst_addr   in   AW  first destination byte address (captured at start)
//   len        in   AW  byte count (captured at start), 0 = no transfer
//   busy       out  1   engine owns the memory port
//   done       out  1   one-cycle completion pulse
//   mem_addr   out  AW  memory address
//   mem_wdata  out  DW  memory write data
//   mem_wr_en  out  1   memory write enable
//   mem_rd_en  out  1   memory read enable (informational)
//   mem_rdata  in   DW  combinational memory read data
//   checksum   out  DW  running byte sum (only with MEM_COPY_CHECKSUM_EN)
//
// All outputs are registered. The next output values are derived from the
// next state. This keeps their timing identical to a state-decoded output,
// and it clears them immediately on reset.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] sum_q, sum_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_wr_en_q, mem_wr_en_d;
    logic          mem_rd_en_q, mem_rd_en_d;

    logic [AW-1:0] idx_inc_s;

    assign idx_inc_s = idx_q + ADDR_ONE;

    // Next-state logic: capture on start, latch read data, advance the index
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = len;
                    idx_d = ADDR_ZERO;
                    sum_d = DATA_ZERO;
                    if (len == ADDR_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                hold_d  = mem_rdata;
                sum_d   = sum_q + mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d = idx_inc_s;
                // The copy is finished once the incremented index reaches len
                if (idx_inc_s == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs match the state
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        mem_rd_en_d = (state_d == ST_READ);
        mem_wr_en_d = (state_d == ST_WRITE);
        mem_addr_d  = ADDR_ZERO;
        mem_wdata_d = DATA_ZERO;
        case (state_d)
            ST_READ: begin
                mem_addr_d = src_d + idx_d;
            end
            ST_WRITE: begin
                mem_addr_d  = dst_d + idx_d;
                mem_wdata_d = hold_d;
            end
            default: begin
                mem_addr_d  = ADDR_ZERO;
                mem_wdata_d = DATA_ZERO;
            end
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= ADDR_ZERO;
            dst_q       <= ADDR_ZERO;
            len_q       <= ADDR_ZERO;
            idx_q       <= ADDR_ZERO;
            hold_q      <= DATA_ZERO;
            sum_q       <= DATA_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= ADDR_ZERO;
            mem_wdata_q <= DATA_ZERO;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            sum_q       <= sum_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;

`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum = sum_q;
`else
    // Without the checksum port, the running sum register has no reader
    logic unused_sum_s;
    assign unused_sum_s = ^sum_q;
`endif

endmodule
